// File: rtl/memory_pkg.sv
// memory_pkg: shared constants and types for the memory arbiter slice.
//   DEFAULT_DEPTH           RAM size in 32-bit words
//   DEFAULT_MAX_DATA_STREAK consecutive contended data grants before fetch wins
//   WORD_W                  data/address word width
//   lock_e                  lock FSM state encoding
//   REQ_FETCH / REQ_DATA    requester ids, also bit positions in the grant vector
package memory_pkg;

    localparam int DEFAULT_DEPTH = 8192;
    localparam int DEFAULT_MAX_DATA_STREAK = 4;
    localparam int WORD_W = 32;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } lock_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: request/response and RAM pins shared by the arbiter.
//   if_req_* / if_rsp_*  instruction-fetch requester
//   d_req_*  / d_rsp_*   load/store requester
//   ram_*                single-port RAM pins
//   slave  modport: arbiter side
//   master modport: requesters plus RAM side
interface memory_arbiter_if;
    import memory_pkg::*;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [WORD_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [WORD_W-1:0] if_rsp_data;
    logic              if_rsp_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [WORD_W-1:0] d_req_addr;
    logic              d_req_we;
    logic [WORD_W-1:0] d_req_wdata;
    logic              d_req_lock;
    logic              d_rsp_valid;
    logic [WORD_W-1:0] d_rsp_data;
    logic              d_rsp_err;

    logic [WORD_W-1:0] ram_a;
    logic [WORD_W-1:0] ram_din;
    logic              ram_rw;
    logic [WORD_W-1:0] ram_dout;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_lock,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output ram_a, ram_din, ram_rw,
        input  ram_dout
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_lock,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  ram_a, ram_din, ram_rw,
        output ram_dout
    );

endinterface

// File: rtl/arbiter_priority.sv
// arbiter_priority: combinational grant selection between fetch and data.
//   if_valid, d_valid  request valids
//   lock               lock FSM state; LOCKED shuts fetch out
//   streak             consecutive contended data grants so far
//   grant              one-hot-or-zero grant, indexed by REQ_FETCH / REQ_DATA
//   streak_next        streak value for the next cycle
module arbiter_priority
    import memory_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic       if_valid,
    input  logic       d_valid,
    input  lock_e      lock,
    input  logic [3:0] streak,
    output logic [1:0] grant,
    output logic [3:0] streak_next
);

    logic cap;

    always_comb begin
        cap = streak >= 4'(MAX_DATA_STREAK);
        grant = 2'b00;
        streak_next = 4'd0;
        if (lock == LOCKED) begin
            grant[REQ_DATA] = d_valid;
            streak_next = streak;
        end else begin
            // Data wins contention until the streak reaches the cap.
            grant[REQ_FETCH] = if_valid && !(d_valid && !cap);
            grant[REQ_DATA] = d_valid && !(if_valid && cap);
            streak_next = (if_valid && d_valid && !cap) ? streak + 4'd1 : 4'd0;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between fetch and load/store paths.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    request/response handshakes and RAM pins (slave modport)
// One grant per cycle; the granted side sees its response exactly one cycle
// later, with read data taken straight from ram_dout in that cycle.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input logic             clk,
    input logic             rst_n,
    memory_arbiter_if.slave bus
);

    lock_e             lock_q, lock_d;
    logic [3:0]        streak_q, streak_d;
    logic [1:0]        grant_raw;
    logic              gf, gd;
    logic              f_oor, d_oor;
    logic              rsp_valid_q, rsp_err_q, rsp_side_q, rsp_we_q;
    logic [WORD_W-1:0] rsp_data;

    arbiter_priority #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_prio (
        .if_valid    (bus.if_req_valid),
        .d_valid     (bus.d_req_valid),
        .lock        (lock_q),
        .streak      (streak_q),
        .grant       (grant_raw),
        .streak_next (streak_d)
    );

    // Grants are masked while reset is held so readys and RAM pins stay idle.
    assign gf = grant_raw[REQ_FETCH] && rst_n;
    assign gd = grant_raw[REQ_DATA] && rst_n;
    assign f_oor = bus.if_req_addr >= 32'(DEPTH);
    assign d_oor = bus.d_req_addr >= 32'(DEPTH);

    assign bus.if_req_ready = gf;
    assign bus.d_req_ready = gd;

    assign bus.ram_a = gd ? bus.d_req_addr : gf ? bus.if_req_addr : '0;
    assign bus.ram_din = gd ? bus.d_req_wdata : '0;
    assign bus.ram_rw = gd && bus.d_req_we && !d_oor;

    // Lock follows d_req_lock on every data grant, in range or not.
    always_comb begin
        lock_d = lock_q;
        if (gd) lock_d = bus.d_req_lock ? LOCKED : OPEN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= OPEN;
            streak_q <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_side_q <= REQ_FETCH;
            rsp_we_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            streak_q <= streak_d;
            rsp_valid_q <= gf || gd;
            rsp_err_q <= gd ? d_oor : (gf && f_oor);
            rsp_side_q <= gd ? REQ_DATA : REQ_FETCH;
            rsp_we_q <= gd && bus.d_req_we;
        end
    end

    // Writes and errors return zero data.
    assign rsp_data = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? bus.ram_dout : '0;

    assign bus.if_rsp_valid = rsp_valid_q && (rsp_side_q == REQ_FETCH);
    assign bus.if_rsp_err = bus.if_rsp_valid && rsp_err_q;
    assign bus.if_rsp_data = bus.if_rsp_valid ? rsp_data : '0;

    assign bus.d_rsp_valid = rsp_valid_q && (rsp_side_q == REQ_DATA);
    assign bus.d_rsp_err = bus.d_rsp_valid && rsp_err_q;
    assign bus.d_rsp_data = bus.d_rsp_valid ? rsp_data : '0;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port `random_access_memory` between two requesters: the instruction-fetch path and the load/store data path of `control_unit`.
- Arbitrates one word-addressed access per cycle and drives the RAM `a`/`din`/`rw` pins.
- Returns read data, or a write acknowledge, to the requester that was granted, one cycle after the grant.
- Provides a lock for atomic read-modify-write (swap) and a starvation guard for fetch.

Parameters:
- DEPTH, 8192, RAM size in 32-bit words; an address >= DEPTH is out of range.
- MAX_DATA_STREAK, 4, max consecutive contended data grants before fetch is forced a grant (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- if_req_valid  input  1  fetch request valid.
- if_req_ready  output  1  fetch request granted this cycle.
- if_req_addr  input  32  fetch word address.
- if_rsp_valid  output  1  fetch response valid.
- if_rsp_data  output  32  fetched word.
- if_rsp_err  output  1  fetch address was out of range.
- d_req_valid  input  1  data request valid.
- d_req_ready  output  1  data request granted this cycle.
- d_req_addr  input  32  data word address.
- d_req_we  input  1  1 = write, 0 = read.
- d_req_wdata  input  32  write data.
- d_req_lock  input  1  hold the lock after this access.
- d_rsp_valid  output  1  data response valid (read data or write ack).
- d_rsp_data  output  32  read data; 0 for writes and errors.
- d_rsp_err  output  1  data address was out of range.
- ram_a  output  32  RAM address.
- ram_din  output  32  RAM write data.
- ram_rw  output  1  RAM write enable (1 = write).
- ram_dout  input  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Handshake: a request transfers in any cycle where valid && ready. Requesters hold addr/we/wdata/lock stable while valid && !ready. Responses have no backpressure; requesters must accept them.
- At most one grant per cycle. if_req_ready and d_req_ready are combinational from the valids, lock state and streak counter; they are never both 1.
- RAM drive: ram_a, ram_din and ram_rw are combinational from the granted request in the grant cycle.
  - No grant: ram_a=0, ram_din=0, ram_rw=0.
  - Out-of-range grant: ram_rw forced to 0 (write suppressed); ram_a still driven.
- Response latency is exactly 1 cycle.
  - In cycle N+1 after a grant in cycle N, the granted side's rsp_valid=1 for exactly one cycle.
  - Read: data = ram_dout.
  - Write: data = 0.
  - err=1 if the address was out of range in cycle N; data is then 0.
- Back-to-back grants are legal. The response of grant N and the grant of N+1 share a cycle.
- Lock FSM, states OPEN and LOCKED:
  - OPEN -> LOCKED on a data grant with d_req_lock=1.
  - LOCKED -> OPEN on a data grant with d_req_lock=0.
  - In LOCKED, if_req_ready=0 regardless of the streak counter.
  - An out-of-range locked request still takes the lock.
- Arbitration in OPEN, driven by a 4-bit streak counter:
  - Only one requester valid: it is granted.
  - Both valid and streak < MAX_DATA_STREAK: data wins and streak increments.
  - Both valid and streak == MAX_DATA_STREAK: fetch wins.
  - streak clears on any fetch grant, and on any cycle with if_req_valid=0.
  - In LOCKED, streak holds its value.
- Reset (rst_n low, any time):
  - State -> OPEN, streak=0.
  - All rsp_valid/rsp_err=0, rsp_data=0, ready=0.
  - ram_rw=0, ram_a=0, ram_din=0.
  - An in-flight response is dropped.
  - Outputs resume in the first cycle after deassertion. A request valid in that cycle may be granted.
- Response registers: rsp_valid, rsp_err, the "granted side" flag and "was write" flag are registered. Data is muxed from ram_dout in the response cycle.

Decomposition:
- Shared package `memory_pkg`: DEPTH default, word width 32, lock state encoding (OPEN=0, LOCKED=1), requester id constants (REQ_FETCH=0, REQ_DATA=1).
- One natural sub-module, `arbiter_priority`: combinational grant logic taking both valids, lock state and streak, producing the grant vector and next streak. Response and RAM muxing stay in the top.

Test Plan:
- Fetch only: RAM preloaded mem[5]=0xE3A01005; fetch addr 5 in cycle 0 -> if_req_ready=1 in cycle 0; cycle 1 if_rsp_valid=1, if_rsp_data=0xE3A01005, d_rsp_valid=0.
- Data write then read: write 0xDEADBEEF to 100 in cycle 0, read 100 in cycle 1 -> cycle 0 ram_rw=1; cycle 1 d_rsp_valid=1, data=0; cycle 2 d_rsp_data=0xDEADBEEF.
- Contention with MAX_DATA_STREAK=4: both valid continuously -> grant pattern D,D,D,D,F,D,D,D,D,F; responses routed to the matching side one cycle later.
- Lock: data read 20 with lock=1, fetch valid throughout, data writes 20 with lock=0 three cycles later -> if_req_ready=0 until the unlock grant; fetch granted the cycle after it.
- Out of range: data write to 8192 -> ram_rw=0 that cycle, next cycle d_rsp_valid=1, d_rsp_err=1, data=0; mem contents unchanged.
- Reset mid-operation: assert rst_n=0 in the cycle after a read grant -> no rsp_valid emitted, lock cleared; after release, a fetch is granted and served normally.
